gpioemu_host: RTL and testbench

Bus initiator for the gpioemu multiply/popcount peripheral. It accepts one command (two 24-bit operands) on a valid/ready port and runs the full register sequence on the slow strobe bus: write A1, write A2, write the control register, poll status, read W, optionally read L. It returns the 32-bit product, the overflow flag and the ones count in a single-cycle result pulse. It sits between a host-side sequencer and the gpioemu bus pins and drives saddress/srd/swr/sdata_in of the peripheral.

---
 rtl/gpioemu_host.sv | 221 ++++++++++++++++++++++
 tb/tb_gpioemu_host.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/gpioemu_host.sv
// gpioemu_host: bus initiator for the gpioemu multiply/popcount peripheral.
// Takes one operand pair per command and runs these steps on the strobe bus:
// write A1, write A2, write start, poll status, read W, optional read L.
// It then returns the result in a one-cycle pulse.
// Build option: define GPIOEMU_HOST_ONES_EN to add the L (ones count) read;
// without it res_ones is tied to zero and 0x0398 is never addressed.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for a command, cmd_ready high
// WR_A1   | bus write of operand 1 to 0x0380
// WR_A2   | bus write of operand 2 to 0x0388
// WR_GO   | bus write of zero to 0x03A0 (start)
// POLL    | bus reads of status at 0x03A0 until done or limit
// RD_W    | bus read of the product at 0x0390
// RD_L    | bus read of the ones count at 0x0398
// RESP    | one-cycle result strobe
module gpioemu_host #(
   parameter int STROBE_CYCLES = 2,
   parameter int POLL_LIMIT    = 255
) (
   input  logic        clk,
   input  logic        n_reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [23:0] cmd_a1,
   input  logic [23:0] cmd_a2,
   output logic        res_valid,
   output logic [31:0] res_w,
   output logic [23:0] res_ones,
   output logic        res_ovf,
   output logic        res_timeout,
   output logic        busy,
   output logic [15:0] saddress,
   output logic        srd,
   output logic        swr,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [2:0] {
      S_IDLE, S_WR_A1, S_WR_A2, S_WR_GO, S_POLL, S_RD_W, S_RD_L, S_RESP
   } state_t;

   // Phase down-counter: PH_TOP = SETUP, PH_STB..1 = STROBE, 0 = HOLD.
   localparam logic [4:0]  PH_TOP   = 5'(STROBE_CYCLES + 1);
   localparam logic [4:0]  PH_STB   = 5'(STROBE_CYCLES);
   localparam logic [15:0] POLL_MAX = 16'(POLL_LIMIT);

   localparam logic [15:0] ADDR_A1 = 16'h0380;
   localparam logic [15:0] ADDR_A2 = 16'h0388;
   localparam logic [15:0] ADDR_GO = 16'h03A0;
   localparam logic [15:0] ADDR_W  = 16'h0390;
   localparam logic [15:0] ADDR_L  = 16'h0398;

   state_t      state_q, state_d;
   logic [4:0]  ph_q, ph_d;
   logic [15:0] poll_q, poll_d;
   logic [15:0] poll_inc;
   logic [23:0] a1_q, a1_d;
   logic [23:0] a2_q, a2_d;
   logic [31:0] w_q, w_d;
   logic        ovf_q, ovf_d;
   logic        to_q, to_d;
   logic [15:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        srd_q, srd_d;
   logic        swr_q, swr_d;
   logic        in_stb;
`ifdef GPIOEMU_HOST_ONES_EN
   logic [23:0] ones_q, ones_d;
`endif

   assign poll_inc = poll_q + 16'd1;

   // Next-state sequencing and registered bus pin values for the next cycle.
   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      poll_d  = poll_q;
      a1_d    = a1_q;
      a2_d    = a2_q;
      w_d     = w_q;
      ovf_d   = ovf_q;
      to_d    = to_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      srd_d   = 1'b0;
      swr_d   = 1'b0;
`ifdef GPIOEMU_HOST_ONES_EN
      ones_d  = ones_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               state_d = S_WR_A1;
               ph_d    = PH_TOP;
               a1_d    = cmd_a1;
               a2_d    = cmd_a2;
               poll_d  = '0;
               w_d     = '0;
               ovf_d   = 1'b0;
               to_d    = 1'b0;
`ifdef GPIOEMU_HOST_ONES_EN
               ones_d  = '0;
`endif
            end
         end
         S_RESP: state_d = S_IDLE;
         default: begin
            if (ph_q != 5'd0) begin
               ph_d = ph_q - 5'd1;
            end else begin
               // End of HOLD: read data is sampled here, next transaction starts.
               ph_d = PH_TOP;
               case (state_q)
                  S_WR_A1: state_d = S_WR_A2;
                  S_WR_A2: state_d = S_WR_GO;
                  S_WR_GO: state_d = S_POLL;
                  S_POLL: begin
                     if (bus_rdata[1]) begin
                        ovf_d   = ~bus_rdata[0];
                        state_d = S_RD_W;
                     end else begin
                        poll_d = poll_inc;
                        if (poll_inc == POLL_MAX) begin
                           to_d    = 1'b1;
                           state_d = S_RESP;
                        end
                     end
                  end
                  S_RD_W: begin
                     w_d = bus_rdata;
`ifdef GPIOEMU_HOST_ONES_EN
                     state_d = S_RD_L;
`else
                     state_d = S_RESP;
`endif
                  end
                  S_RD_L: begin
`ifdef GPIOEMU_HOST_ONES_EN
                     ones_d = bus_rdata[23:0];
`endif
                     state_d = S_RESP;
                  end
                  default: state_d = S_IDLE;
               endcase
            end
         end
      endcase

      in_stb = (ph_d != 5'd0) && (ph_d <= PH_STB);

      // Address and write data are set when a transaction's SETUP begins and
      // are held otherwise, so saddress keeps its last value between commands.
      case (state_d)
         S_WR_A1: begin addr_d = ADDR_A1; wdata_d = {8'h00, a1_d}; swr_d = in_stb; end
         S_WR_A2: begin addr_d = ADDR_A2; wdata_d = {8'h00, a2_d}; swr_d = in_stb; end
         S_WR_GO: begin addr_d = ADDR_GO; wdata_d = '0;            swr_d = in_stb; end
         S_POLL:  begin addr_d = ADDR_GO; wdata_d = '0;            srd_d = in_stb; end
         S_RD_W:  begin addr_d = ADDR_W;  wdata_d = '0;            srd_d = in_stb; end
         S_RD_L:  begin addr_d = ADDR_L;  wdata_d = '0;            srd_d = in_stb; end
         default: ;
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state_q <= S_IDLE;
         ph_q    <= '0;
         poll_q  <= '0;
         a1_q    <= '0;
         a2_q    <= '0;
         w_q     <= '0;
         ovf_q   <= 1'b0;
         to_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         srd_q   <= 1'b0;
         swr_q   <= 1'b0;
`ifdef GPIOEMU_HOST_ONES_EN
         ones_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         ph_q    <= ph_d;
         poll_q  <= poll_d;
         a1_q    <= a1_d;
         a2_q    <= a2_d;
         w_q     <= w_d;
         ovf_q   <= ovf_d;
         to_q    <= to_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         srd_q   <= srd_d;
         swr_q   <= swr_d;
`ifdef GPIOEMU_HOST_ONES_EN
         ones_q  <= ones_d;
`endif
      end
   end

   assign cmd_ready   = (state_q == S_IDLE);
   assign busy        = ~cmd_ready;
   assign res_valid   = (state_q == S_RESP);
   assign res_w       = w_q;
   assign res_ovf     = ovf_q;
   assign res_timeout = to_q;
   assign saddress    = addr_q;
   assign srd         = srd_q;
   assign swr         = swr_q;
   assign bus_wdata   = wdata_q;
`ifdef GPIOEMU_HOST_ONES_EN
   assign res_ones    = ones_q;
`else
   assign res_ones    = '0;
`endif

endmodule

// File: tb/tb_gpioemu_host.sv
// Directed bench for gpioemu_host with a behavioural gpioemu peripheral and
// a bus protocol monitor running alongside every command.
`timescale 1ns/1ps
module tb_gpioemu_host;

   localparam int SC = 2;
   localparam int PL = 4;
`ifdef GPIOEMU_HOST_ONES_EN
   localparam bit ONES = 1'b1;
`else
   localparam bit ONES = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        n_reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [23:0] cmd_a1, cmd_a2;
   logic        res_valid;
   logic [31:0] res_w;
   logic [23:0] res_ones;
   logic        res_ovf, res_timeout, busy;
   logic [15:0] saddress;
   logic        srd, swr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;

   gpioemu_host #(.STROBE_CYCLES(SC), .POLL_LIMIT(PL)) dut (
      .clk(clk), .n_reset(n_reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a1(cmd_a1), .cmd_a2(cmd_a2), .res_valid(res_valid), .res_w(res_w),
      .res_ones(res_ones), .res_ovf(res_ovf), .res_timeout(res_timeout), .busy(busy),
      .saddress(saddress), .srd(srd), .swr(swr), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Peripheral model state
   logic [23:0] m_a1 = '0, m_a2 = '0;
   logic [47:0] m_prod;
   logic [31:0] m_w;
   int          stat_reads = 0, stat_base = 0, done_at = 1;
   logic [1:0]  m_stat = 2'b11;
   int          w_reads = 0, l_reads = 0, go_bad = 0, acc_cnt = 0;
   // Protocol monitor state
   logic        prev_rd = 1'b0, prev_wr = 1'b0, prev_rst_ok = 1'b0;
   logic [15:0] prev_addr = '0;
   int          run = 0, both_cnt = 0, addr_err = 0, width_err = 0;

   assign m_prod = {24'h0, m_a1} * {24'h0, m_a2};
   assign m_w    = m_prod[31:0];

   always_comb begin
      bus_rdata = 32'h0;
      case (saddress)
         16'h03A0: bus_rdata = ((stat_reads - stat_base) >= done_at) ? {30'h0, m_stat} : 32'h1;
         16'h0390: bus_rdata = m_w;
         16'h0398: bus_rdata = {8'hA5, 24'($countones(m_w))};
         default:  bus_rdata = 32'hDEAD_BEEF;
      endcase
   end

   // Peripheral register capture and bus protocol monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (swr && !prev_wr) begin
         if (saddress == 16'h0380) m_a1 <= bus_wdata[23:0];
         if (saddress == 16'h0388) m_a2 <= bus_wdata[23:0];
         if (saddress == 16'h03A0 && bus_wdata != 32'h0) go_bad <= go_bad + 1;
      end
      if (srd && !prev_rd) begin
         if (saddress == 16'h03A0) stat_reads <= stat_reads + 1;
         if (saddress == 16'h0390) w_reads <= w_reads + 1;
         if (saddress == 16'h0398) l_reads <= l_reads + 1;
      end
      if (n_reset && cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;
      if (n_reset && prev_rst_ok) begin
         if (srd && swr) both_cnt <= both_cnt + 1;
         if ((srd || swr || prev_rd || prev_wr) && saddress != prev_addr)
            addr_err <= addr_err + 1;
         if (srd || swr) run <= run + 1;
         else if (prev_rd || prev_wr) begin
            if (run != SC) width_err <= width_err + 1;
            run <= 0;
         end
      end else begin
         run <= 0;
      end
      prev_rd     <= srd;
      prev_wr     <= swr;
      prev_addr   <= saddress;
      prev_rst_ok <= n_reset;
   end

   task automatic run_cmd(input string tag, input logic [23:0] a1, input logic [23:0] a2,
                          input int d_at, input logic [1:0] st, input logic [31:0] ew,
                          input logic [23:0] eones, input logic eovf, input logic eto,
                          input int elat, input int estat);
      int acc0, sr0, w0, l0, cyc;
      acc0 = acc_cnt; sr0 = stat_reads; w0 = w_reads; l0 = l_reads;
      stat_base = stat_reads; done_at = d_at; m_stat = st;
      cmd_valid = 1'b1; cmd_a1 = a1; cmd_a2 = a2;
      @(posedge clk); #1;
      cmd_a1 = ~a1; cmd_a2 = ~a2;
      cyc = 1;
      chk({tag, "_ready_low"}, 32'(cmd_ready), 32'd0);
      while (!res_valid && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 10) cmd_valid = 1'b0;
      end
      cmd_valid = 1'b0;
      chk({tag, "_latency"}, 32'(cyc), 32'(elat));
      chk({tag, "_w"}, res_w, ew);
      chk({tag, "_ones"}, 32'(res_ones), 32'(eones));
      chk({tag, "_ovf"}, 32'(res_ovf), 32'(eovf));
      chk({tag, "_timeout"}, 32'(res_timeout), 32'(eto));
      chk({tag, "_busy_resp"}, 32'(busy), 32'd1);
      @(posedge clk); #1;
      chk({tag, "_valid_drop"}, 32'(res_valid), 32'd0);
      chk({tag, "_ready_back"}, 32'(cmd_ready), 32'd1);
      chk({tag, "_w_stable"}, res_w, ew);
      chk({tag, "_stat_reads"}, 32'(stat_reads - sr0), 32'(estat));
      chk({tag, "_w_reads"}, 32'(w_reads - w0), eto ? 32'd0 : 32'd1);
      chk({tag, "_l_reads"}, 32'(l_reads - l0), (ONES && !eto) ? 32'd1 : 32'd0);
      chk({tag, "_accepts"}, 32'(acc_cnt - acc0), 32'd1);
      chk({tag, "_proto_both"}, 32'(both_cnt), 32'd0);
      chk({tag, "_proto_addr"}, 32'(addr_err), 32'd0);
      chk({tag, "_proto_width"}, 32'(width_err), 32'd0);
      chk({tag, "_go_data"}, 32'(go_bad), 32'd0);
   endtask

   initial begin
      int npoll, seen_valid, cyc;
      logic rd_prev;
      n_reset = 1'b0; cmd_valid = 1'b0; cmd_a1 = '0; cmd_a2 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(res_valid), 32'd0);
      chk("rst_w", res_w, 32'd0);
      chk("rst_ones", 32'(res_ones), 32'd0);
      chk("rst_flags", {30'd0, res_ovf, res_timeout}, 32'd0);
      chk("rst_bus", {14'd0, saddress, srd, swr}, 32'd0);
      chk("rst_wdata", bus_wdata, 32'd0);
      n_reset = 1'b1;
      @(posedge clk); #1;

      run_cmd("mul", 24'd3, 24'd5, 2, 2'b11, 32'h0000_000F, ONES ? 24'd4 : 24'd0,
              1'b0, 1'b0, ONES ? 29 : 25, 2);
      run_cmd("ovf", 24'hFF_FFFF, 24'hFF_FFFF, 1, 2'b10, 32'hFE00_0001,
              ONES ? 24'd8 : 24'd0, 1'b1, 1'b0, ONES ? 25 : 21, 1);
      run_cmd("tmo", 24'd7, 24'd9, 1000, 2'b11, 32'h0, 24'd0, 1'b0, 1'b1, 29, 4);

      // Reset during the second status read strobe
      stat_base = stat_reads; done_at = 3; m_stat = 2'b11;
      cmd_valid = 1'b1; cmd_a1 = 24'd11; cmd_a2 = 24'd13;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      npoll = 0; rd_prev = 1'b0; cyc = 0;
      while (cyc < 100) begin
         if (srd && !rd_prev && saddress == 16'h03A0) npoll++;
         if (npoll == 2 && srd) break;
         rd_prev = srd;
         @(posedge clk); #1;
         cyc++;
      end
      chk("rstmid_found", 32'(npoll), 32'd2);
      n_reset = 1'b0;
      @(posedge clk); #1;
      chk("rstmid_srd", 32'(srd), 32'd0);
      chk("rstmid_ready", 32'(cmd_ready), 32'd1);
      chk("rstmid_valid", 32'(res_valid), 32'd0);
      n_reset = 1'b1;
      seen_valid = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (res_valid) seen_valid++;
      end
      chk("rstmid_no_valid", 32'(seen_valid), 32'd0);
      chk("rstmid_idle_bus", {30'd0, srd, swr}, 32'd0);

      run_cmd("fresh", 24'h00_1234, 24'h00_0010, 1, 2'b11, 32'h0001_2340,
              ONES ? 24'd5 : 24'd0, 1'b0, 1'b0, ONES ? 25 : 21, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
